// File: rtl/video_lut_mc.sv
// ---------------------------------------------------------------------------
// video_lut_mc
// Multi-channel per-pixel lookup table (gamma / tone curve) with two LUT
// banks. The host programs the shadow bank through an indirect register
// port while the pixel path reads the active bank. Banks swap on a rising
// edge of vs_i once a swap has been requested, so a frame never mixes banks.
//
// Optional feature macro: VIDEO_LUT_MC_BYPASS_EN
//   When defined, adds input 'bypass', which routes the raw pixel (MSB
//   aligned to DO_WIDTH) to the output instead of the LUT result.
//
// Ports:
//   clk            single clock for host port and pixel path
//   rst            synchronous reset, active-low
//   ram_addr       {channel[1:0], entry[DI_WIDTH-1:0]} host address
//   ram_wdata      host write data
//   ram_wr         host write strobe (one word per cycle)
//   ram_rd         host read strobe
//   ram_rdata      host read data, valid while ram_rvalid is high
//   ram_rvalid     one-cycle pulse one cycle after ram_rd
//   lut_swap       bank swap request pulse
//   lut_swap_done  one-cycle pulse on the edge where the swap lands
//   lut_bank       index of the active bank
//   di_i           packed input pixels, ch0 in LSBs
//   de_i/hs_i/vs_i input video strobes
//   bypass         (VIDEO_LUT_MC_BYPASS_EN only) raw pass-through select
//   do_o           packed output pixels, ch0 in LSBs, 2-cycle latency
//   de_o/hs_o/vs_o strobes delayed by 2 cycles, aligned with do_o
// ---------------------------------------------------------------------------
module video_lut_mc #(
  parameter int CH_COUNT = 3,
  parameter int DI_WIDTH = 10,
  parameter int DO_WIDTH = 8,
  parameter int LUT_DW   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DI_WIDTH+1:0]          ram_addr,
  input  logic [LUT_DW-1:0]            ram_wdata,
  input  logic                         ram_wr,
  input  logic                         ram_rd,
  output logic [LUT_DW-1:0]            ram_rdata,
  output logic                         ram_rvalid,
  input  logic                         lut_swap,
  output logic                         lut_swap_done,
  output logic                         lut_bank,
  input  logic [CH_COUNT*DI_WIDTH-1:0] di_i,
  input  logic                         de_i,
  input  logic                         hs_i,
  input  logic                         vs_i,
`ifdef VIDEO_LUT_MC_BYPASS_EN
  input  logic                         bypass,
`endif
  output logic [CH_COUNT*DO_WIDTH-1:0] do_o,
  output logic                         de_o,
  output logic                         hs_o,
  output logic                         vs_o
);

  localparam logic [2:0] CH_LIMIT = 3'(CH_COUNT);

  logic [1:0]          host_ch;
  logic [DI_WIDTH-1:0] host_entry;
  logic                host_ok;
  logic                shadow_bank;
  logic                vs_q;
  logic                vs_rise;
  logic                swap_pending;

  logic                rd_ok_q;
  logic                rd_wr_q;
  logic [1:0]          rd_ch_q;
  logic [LUT_DW-1:0]   wdata_q;
  logic [4*LUT_DW-1:0] host_bus;

  logic                de_1, hs_1, vs_1;
`ifdef VIDEO_LUT_MC_BYPASS_EN
  logic                byp_1;
`endif

  assign host_ch     = ram_addr[DI_WIDTH +: 2];
  assign host_entry  = ram_addr[DI_WIDTH-1:0];
  assign host_ok     = ({1'b0, host_ch} < CH_LIMIT);
  assign shadow_bank = ~lut_bank;
  assign vs_rise     = vs_i & ~vs_q;

  // Bank swap control. A request received in the same cycle as the vs
  // rising edge takes effect immediately; otherwise it waits as pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lut_bank      <= 1'b0;
      swap_pending  <= 1'b0;
      lut_swap_done <= 1'b0;
      vs_q          <= 1'b0;
    end else begin
      vs_q          <= vs_i;
      lut_swap_done <= 1'b0;
      if (vs_rise && (swap_pending || lut_swap)) begin
        lut_bank      <= ~lut_bank;
        swap_pending  <= 1'b0;
        lut_swap_done <= 1'b1;
      end else if (lut_swap) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Host read bookkeeping. The RAM read word is captured per channel; a
  // write in the same cycle is forwarded from wdata_q because the RAM read
  // returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_rvalid <= 1'b0;
      rd_ok_q    <= 1'b0;
      rd_wr_q    <= 1'b0;
      rd_ch_q    <= 2'd0;
      wdata_q    <= '0;
    end else begin
      ram_rvalid <= ram_rd;
      if (ram_rd) begin
        rd_ok_q <= host_ok;
        rd_wr_q <= ram_wr;
        rd_ch_q <= host_ch;
        wdata_q <= ram_wdata;
      end
    end
  end

  assign ram_rdata = !rd_ok_q ? '0 :
                     rd_wr_q  ? wdata_q :
                                host_bus[int'(rd_ch_q)*LUT_DW +: LUT_DW];

  // Strobe delay line, two stages to match the pixel path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      de_1 <= 1'b0;
      hs_1 <= 1'b0;
      vs_1 <= 1'b0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      de_1 <= de_i;
      hs_1 <= hs_i;
      vs_1 <= vs_i;
      de_o <= de_1;
      hs_o <= hs_1;
      vs_o <= vs_1;
    end
  end

`ifdef VIDEO_LUT_MC_BYPASS_EN
  always_ff @(posedge clk) begin
    if (!rst) byp_1 <= 1'b0;
    else      byp_1 <= bypass;
  end
`endif

  for (genvar c = 0; c < 4; c++) begin : g_lane
    if (c < CH_COUNT) begin : g_ch
      logic [LUT_DW-1:0]   mem [2**(DI_WIDTH+1)];
      logic [LUT_DW-1:0]   pix_word;
      logic [LUT_DW-1:0]   host_word;
      logic [DI_WIDTH-1:0] di_c;
      logic [DO_WIDTH-1:0] sat_val;
      logic [DO_WIDTH-1:0] out_q;
      logic                wr_hit;

      assign di_c   = di_i[c*DI_WIDTH +: DI_WIDTH];
      assign wr_hit = ram_wr && (host_ch == 2'(c));

      // Address {bank, entry}: host side always uses the shadow bank,
      // pixel side the active bank, so the two never collide.
      always_ff @(posedge clk) begin
        if (wr_hit) mem[{shadow_bank, host_entry}] <= ram_wdata;
        if (ram_rd) host_word <= mem[{shadow_bank, host_entry}];
        if (!rst) pix_word <= '0;
        else      pix_word <= mem[{lut_bank, di_c}];
      end

      // Any set bit above the output width clamps to full scale.
      if (LUT_DW > DO_WIDTH) begin : g_sat
        assign sat_val = (|pix_word[LUT_DW-1:DO_WIDTH]) ? {DO_WIDTH{1'b1}}
                                                        : pix_word[DO_WIDTH-1:0];
      end else begin : g_nosat
        assign sat_val = pix_word[DO_WIDTH-1:0];
      end

`ifdef VIDEO_LUT_MC_BYPASS_EN
      logic [DI_WIDTH-1:0] di_q;
      logic [DO_WIDTH-1:0] byp_val;

      always_ff @(posedge clk) begin
        if (!rst) di_q <= '0;
        else      di_q <= di_c;
      end

      if (DI_WIDTH >= DO_WIDTH) begin : g_byp_trunc
        assign byp_val = di_q[DI_WIDTH-1 -: DO_WIDTH];
      end else begin : g_byp_widen
        assign byp_val = {di_q, {(DO_WIDTH-DI_WIDTH){1'b0}}};
      end

      always_ff @(posedge clk) begin
        if (!rst) out_q <= '0;
        else      out_q <= byp_1 ? byp_val : sat_val;
      end
`else
      always_ff @(posedge clk) begin
        if (!rst) out_q <= '0;
        else      out_q <= sat_val;
      end
`endif

      assign do_o[c*DO_WIDTH +: DO_WIDTH]   = out_q;
      assign host_bus[c*LUT_DW +: LUT_DW]   = host_word;
    end else begin : g_none
      assign host_bus[c*LUT_DW +: LUT_DW]   = '0;
    end
  end

endmodule

// File: tb/tb_video_lut_mc.sv
// ---------------------------------------------------------------------------
// tb_video_lut_mc
// Self-checking bench for video_lut_mc (default parameters). A behavioural
// model (LUT arrays, clamp arithmetic, two-entry output delay) is advanced
// every clock and compared with the DUT; table-driven vectors and hand
// sequences add fixed expected values for the key corner cases.
// Build with VIDEO_LUT_MC_BYPASS_EN to also exercise the bypass path.
// ---------------------------------------------------------------------------
module tb_video_lut_mc;

  localparam int CH    = 3;
  localparam int DIW   = 10;
  localparam int DOW   = 8;
  localparam int LDW   = 16;
  localparam int DEPTH = 1 << DIW;

  logic                clk = 1'b0;
  logic                rst;
  logic [DIW+1:0]      ram_addr;
  logic [LDW-1:0]      ram_wdata;
  logic                ram_wr, ram_rd;
  logic [LDW-1:0]      ram_rdata;
  logic                ram_rvalid;
  logic                lut_swap, lut_swap_done, lut_bank;
  logic [CH*DIW-1:0]   di_i;
  logic                de_i, hs_i, vs_i;
  logic [CH*DOW-1:0]   do_o;
  logic                de_o, hs_o, vs_o;
  logic                byp_drv;

  always #5 clk = ~clk;

  video_lut_mc #(.CH_COUNT(CH), .DI_WIDTH(DIW), .DO_WIDTH(DOW), .LUT_DW(LDW)) dut (
    .clk(clk), .rst(rst),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .lut_swap(lut_swap), .lut_swap_done(lut_swap_done), .lut_bank(lut_bank),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
`ifdef VIDEO_LUT_MC_BYPASS_EN
    .bypass(byp_drv),
`endif
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  typedef struct packed {
    logic [CH*DOW-1:0] pix;
    logic              de, hs, vs;
  } stage_t;

  typedef struct {
    int          ch;
    int          entry;
    logic [15:0] word;
    logic [7:0]  exp_out;
  } sat_vec_t;

  typedef struct {
    bit          wr, rd;
    int          ch;
    int          entry;
    logic [15:0] wdata;
    bit          exp_valid;
    logic [15:0] exp_rdata;
  } host_vec_t;

  logic [LDW-1:0] mdl_mem [2][CH][DEPTH];
  bit             mdl_bank, mdl_pend, mdl_done, mdl_vs_prev, mdl_rvalid;
  logic [LDW-1:0] mdl_rdata;
  stage_t         mdl_s1, mdl_s2;
  bit             pix_check_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  function automatic logic [DOW-1:0] lutOut(input logic [LDW-1:0] w);
    if (int'(w) > (1 << DOW) - 1) return {DOW{1'b1}};
    return DOW'(w);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs being driven, then compare
  // the DUT a little after the edge.
  task automatic applyStimulus();
    stage_t         nxt;
    logic [1:0]     ch;
    logic [DIW-1:0] e, d;
    bit             ok;
    logic [LDW-1:0] rdv;
    ch  = ram_addr[DIW+1:DIW];
    e   = ram_addr[DIW-1:0];
    ok  = int'(ch) < CH;
    nxt = '0;
    for (int c = 0; c < CH; c++) begin
      d = di_i[c*DIW +: DIW];
      nxt.pix[c*DOW +: DOW] = byp_drv ? DOW'(d >> (DIW - DOW))
                                      : lutOut(mdl_mem[mdl_bank][c][d]);
    end
    nxt.de = de_i; nxt.hs = hs_i; nxt.vs = vs_i;
    rdv = !ok ? '0 : ram_wr ? ram_wdata : mdl_mem[!mdl_bank][ch][e];
    if (ram_wr && ok) mdl_mem[!mdl_bank][ch][e] = ram_wdata;
    if (!rst) begin
      mdl_bank = 0; mdl_pend = 0; mdl_done = 0; mdl_vs_prev = 0;
      mdl_rvalid = 0; mdl_rdata = '0; mdl_s1 = '0; mdl_s2 = '0;
    end else begin
      mdl_s2     = mdl_s1;
      mdl_s1     = nxt;
      mdl_rvalid = ram_rd;
      if (ram_rd) mdl_rdata = rdv;
      mdl_done = 0;
      if (vs_i && !mdl_vs_prev && (mdl_pend || lut_swap)) begin
        mdl_bank = !mdl_bank;
        mdl_pend = 0;
        mdl_done = 1;
      end else if (lut_swap) begin
        mdl_pend = 1;
      end
      mdl_vs_prev = vs_i;
    end
    @(posedge clk);
    #1;
    if (pix_check_en) checkOutput("mdl_do_o", do_o, mdl_s2.pix);
    checkOutput("mdl_de_o", de_o, mdl_s2.de);
    checkOutput("mdl_hs_o", hs_o, mdl_s2.hs);
    checkOutput("mdl_vs_o", vs_o, mdl_s2.vs);
    checkOutput("mdl_lut_bank", lut_bank, mdl_bank);
    checkOutput("mdl_swap_done", lut_swap_done, mdl_done);
    checkOutput("mdl_rvalid", ram_rvalid, mdl_rvalid);
    if (mdl_rvalid) checkOutput("mdl_rdata", ram_rdata, mdl_rdata);
  endtask

  task automatic hostWrite(input int ch, input int entry, input logic [15:0] data);
    ram_wr    = 1'b1;
    ram_addr  = {2'(ch), DIW'(entry)};
    ram_wdata = data;
    applyStimulus();
    ram_wr    = 1'b0;
  endtask

  task automatic doSwap();
    lut_swap = 1'b1; vs_i = 1'b0;
    applyStimulus();
    lut_swap = 1'b0; vs_i = 1'b1;
    applyStimulus();
    vs_i = 1'b0;
    applyStimulus();
  endtask

  sat_vec_t  sat_tab  [6];
  host_vec_t host_tab [7];
  bit        b0;

  initial begin
    sat_tab[0] = '{1, 5,    16'h0123, 8'hFF};
    sat_tab[1] = '{1, 5,    16'h0042, 8'h42};
    sat_tab[2] = '{0, 0,    16'h00FF, 8'hFF};
    sat_tab[3] = '{2, 1023, 16'h0100, 8'hFF};
    sat_tab[4] = '{0, 7,    16'h0000, 8'h00};
    sat_tab[5] = '{2, 3,    16'h8000, 8'hFF};

    host_tab[0] = '{1, 0, 1, 10, 16'h1234, 0, 16'h0000};
    host_tab[1] = '{0, 1, 1, 10, 16'h0000, 1, 16'h1234};
    host_tab[2] = '{1, 1, 2, 20, 16'hABCD, 1, 16'hABCD};
    host_tab[3] = '{0, 1, 2, 20, 16'h0000, 1, 16'hABCD};
    host_tab[4] = '{1, 0, 3, 5,  16'h5555, 0, 16'h0000};
    host_tab[5] = '{0, 1, 3, 5,  16'h0000, 1, 16'h0000};
    host_tab[6] = '{1, 1, 3, 6,  16'h7777, 1, 16'h0000};

    rst = 1'b0; ram_addr = '0; ram_wdata = '0; ram_wr = 1'b0; ram_rd = 1'b0;
    lut_swap = 1'b0; di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; byp_drv = 1'b0;
    mdl_s1 = '0; mdl_s2 = '0; mdl_rdata = '0;

    // Reset state
    repeat (3) applyStimulus();
    checkOutput("reset_do_o", do_o, 0);
    checkOutput("reset_de_o", de_o, 0);
    checkOutput("reset_bank", lut_bank, 0);
    checkOutput("reset_rvalid", ram_rvalid, 0);
    checkOutput("reset_rdata", ram_rdata, 0);
    rst = 1'b1;
    applyStimulus();

    // Identity curve into the shadow bank, then swap on a vs rising edge
    for (int c = 0; c < CH; c++)
      for (int n = 0; n < DEPTH; n++) hostWrite(c, n, 16'(n >> 2));
    lut_swap = 1'b1;
    applyStimulus();
    lut_swap = 1'b0; vs_i = 1'b1;
    applyStimulus();
    checkOutput("first_swap_done", lut_swap_done, 1);
    checkOutput("first_swap_bank", lut_bank, 1);
    applyStimulus();
    checkOutput("first_swap_done_once", lut_swap_done, 0);
    vs_i = 1'b0;
    di_i[DIW-1:0] = 10'h3FF; de_i = 1'b1;
    applyStimulus();
    de_i = 1'b0; di_i = '0;
    checkOutput("identity_lat1_de", de_o, 0);
    applyStimulus();
    checkOutput("identity_do_ch0", do_o[DOW-1:0], 8'hFF);
    checkOutput("identity_de_o", de_o, 1);
    applyStimulus();
    checkOutput("identity_de_o_drop", de_o, 0);

    // Fill the other bank with a mix of in-range and saturating words
    for (int c = 0; c < CH; c++)
      for (int n = 0; n < DEPTH; n++) hostWrite(c, n, 16'($urandom_range(0, 511)));
    pix_check_en = 1'b1;

    // Saturation vectors: program, swap, look up
    for (int i = 0; i < 6; i++) begin
      hostWrite(sat_tab[i].ch, sat_tab[i].entry, sat_tab[i].word);
      doSwap();
      di_i = CH*DIW'($urandom);
      di_i[sat_tab[i].ch*DIW +: DIW] = DIW'(sat_tab[i].entry);
      de_i = 1'b1;
      applyStimulus();
      de_i = 1'b0;
      applyStimulus();
      checkOutput("sat_tab", do_o[sat_tab[i].ch*DOW +: DOW], sat_tab[i].exp_out);
    end

    // Host port vectors
    for (int i = 0; i < 7; i++) begin
      ram_wr    = host_tab[i].wr;
      ram_rd    = host_tab[i].rd;
      ram_addr  = {2'(host_tab[i].ch), DIW'(host_tab[i].entry)};
      ram_wdata = host_tab[i].wdata;
      applyStimulus();
      ram_wr = 1'b0; ram_rd = 1'b0;
      checkOutput("host_rvalid", ram_rvalid, host_tab[i].exp_valid);
      if (host_tab[i].exp_valid) checkOutput("host_rdata", ram_rdata, host_tab[i].exp_rdata);
    end
    applyStimulus();
    checkOutput("host_rvalid_pulse", ram_rvalid, 0);

    // Swap timing: mid-frame requests wait for the next vs rising edge
    hostWrite(0, 9, 16'h0033);
    doSwap();
    hostWrite(0, 9, 16'h0022);
    b0 = mdl_bank;
    vs_i = 1'b1;
    applyStimulus();
    checkOutput("rise_no_request_bank", lut_bank, b0);
    checkOutput("rise_no_request_done", lut_swap_done, 0);
    repeat (3) begin
      lut_swap = 1'b1; applyStimulus();
      lut_swap = 1'b0; applyStimulus();
    end
    checkOutput("swap_held_midframe", lut_bank, b0);
    di_i = '0; di_i[DIW-1:0] = 10'd9; de_i = 1'b1;
    vs_i = 1'b0;
    applyStimulus();
    vs_i = 1'b1;
    applyStimulus();
    checkOutput("swap_edge_done", lut_swap_done, 1);
    checkOutput("swap_edge_bank", lut_bank, !b0);
    applyStimulus();
    checkOutput("swap_edge_done_once", lut_swap_done, 0);
    checkOutput("pixel_old_bank", do_o[DOW-1:0], 8'h33);
    applyStimulus();
    checkOutput("pixel_new_bank", do_o[DOW-1:0], 8'h22);
    vs_i = 1'b0; applyStimulus();
    vs_i = 1'b1; applyStimulus();
    checkOutput("collapsed_single_toggle", lut_bank, !b0);
    checkOutput("collapsed_no_second_done", lut_swap_done, 0);
    vs_i = 1'b0; de_i = 1'b0;
    applyStimulus();

    // Reset mid-line
    de_i = 1'b1;
    repeat (3) begin di_i = CH*DIW'($urandom); applyStimulus(); end
    rst = 1'b0;
    applyStimulus();
    checkOutput("midline_reset_do", do_o, 0);
    checkOutput("midline_reset_de", de_o, 0);
    checkOutput("midline_reset_bank", lut_bank, 0);
    rst = 1'b1; de_i = 1'b0;
    applyStimulus();
    de_i = 1'b1;
    applyStimulus();
    de_i = 1'b0;
    checkOutput("post_reset_lat1_de", de_o, 0);
    applyStimulus();
    checkOutput("post_reset_lat2_de", de_o, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) != 0);
      ram_wr    = $urandom_range(0, 3) == 0;
      ram_rd    = $urandom_range(0, 2) == 0;
      ram_addr  = DIW'($urandom) | ((DIW+2)'($urandom_range(0, 3)) << DIW);
      ram_wdata = 16'($urandom);
      lut_swap  = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 7) == 0) vs_i = ~vs_i;
      de_i      = $urandom_range(0, 1) == 1;
      hs_i      = $urandom_range(0, 9) == 0;
      di_i      = CH*DIW'($urandom);
      applyStimulus();
    end
    rst = 1'b1; ram_wr = 1'b0; ram_rd = 1'b0; lut_swap = 1'b0;

`ifdef VIDEO_LUT_MC_BYPASS_EN
    // Raw pass-through, toggled per pixel
    byp_drv = 1'b1;
    di_i = '0; di_i[2*DIW +: DIW] = 10'h2A5;
    applyStimulus();
    byp_drv = 1'b0;
    applyStimulus();
    checkOutput("bypass_ch2", do_o[2*DOW +: DOW], 8'hA9);
    for (int i = 0; i < 300; i++) begin
      byp_drv = $urandom_range(0, 1) == 1;
      de_i    = $urandom_range(0, 1) == 1;
      di_i    = CH*DIW'($urandom);
      applyStimulus();
    end
    byp_drv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_lut_mc.md
Name: video_lut_mc

Overview:
- Multi-channel per-pixel lookup table (gamma/tone curve) for the video filter chain; sits between capture and downstream scalers.
- Successor to the single-channel LUT converter: parametrised channel count and widths, double-buffered LUT banks swapped on frame boundary, saturation on output, and a read-valid handshake on the host port.
- Host programs the shadow bank through the indirect register port; the pixel path always reads the active bank.

Parameters:
- CH_COUNT, 3, number of parallel pixel channels (1..4)
- DI_WIDTH, 10, input sample width per channel; LUT depth = 2**DI_WIDTH (8..10)
- DO_WIDTH, 8, output sample width per channel (1..LUT_DW)
- LUT_DW, 16, stored LUT word width (DO_WIDTH..16)

Ports:
- clk  in  1  single clock for host port and pixel path
- rst  in  1  synchronous reset, active-low (0 = reset)
- ram_addr  in  DI_WIDTH+2  {channel[1:0], entry[DI_WIDTH-1:0]}
- ram_wdata  in  LUT_DW  write data
- ram_wr  in  1  write strobe, one word per cycle
- ram_rd  in  1  read strobe
- ram_rdata  out  LUT_DW  read data
- ram_rvalid  out  1  one-cycle pulse, ram_rdata valid
- lut_swap  in  1  request bank swap (pulse)
- lut_swap_done  out  1  one-cycle pulse when swap takes effect
- lut_bank  out  1  index of active bank
- di_i  in  CH_COUNT*DI_WIDTH  packed pixels, ch0 in LSBs
- de_i, hs_i, vs_i  in  1 each  video strobes, active-high
- do_o  out  CH_COUNT*DO_WIDTH  packed output, ch0 in LSBs
- de_o, hs_o, vs_o  out  1 each  delayed strobes

Behaviour:
- Reset (rst=0 at clk edge): lut_bank=0, swap pending=0, lut_swap_done=0, ram_rvalid=0, ram_rdata=0, do_o=0, de_o/hs_o/vs_o=0, vs edge detector cleared. LUT contents not reset.
- Storage: 2 banks x CH_COUNT x 2**DI_WIDTH words of LUT_DW. Host accesses target the shadow bank (!lut_bank) only.
- Host write: ram_wr=1 with channel<CH_COUNT stores ram_wdata. channel>=CH_COUNT is ignored.
- Host read: ram_rd=1 gives ram_rvalid=1 on the next cycle, with ram_rdata = shadow[channel][entry]. If channel>=CH_COUNT, ram_rdata=0.
- Write and read in the same cycle: the write is performed, and ram_rdata returns ram_wdata next cycle.
- Swap: lut_swap=1 sets pending. On a rising edge of vs_i (vs_i=1 and registered vs_i=0) with pending set, or with lut_swap=1 in that same cycle, lut_bank toggles, pending clears and lut_swap_done pulses, all on that clock edge. Repeated requests before the edge collapse into one swap.
- Host writes issued in the swap cycle go to the pre-swap shadow bank.
- Pixel path latency: fixed 2 cycles for all outputs.
  - Stage 1: registered RAM read of active[ch][di_i ch slice].
  - Stage 2: saturate. If word[LUT_DW-1:DO_WIDTH] != 0, output all-ones, else word[DO_WIDTH-1:0].
- de/hs/vs are delayed 2 cycles, aligned with do_o. The LUT lookup runs regardless of de_i.
- The bank used for a pixel is the value of lut_bank in the cycle the pixel enters stage 1. The swap lands on the vs edge, so no frame mixes banks.
- Reset mid-frame: pipeline and strobes are forced to 0, and output resumes 2 cycles after rst returns to 1.

Optional Feature:
- VIDEO_LUT_MC_BYPASS_EN defined: adds input port bypass (1 bit), sampled with the pixel at stage 1.
  - When 1, each channel output = di[DI_WIDTH-1 -: DO_WIDTH] if DI_WIDTH>=DO_WIDTH, else di left-shifted by DO_WIDTH-DI_WIDTH (zero-filled LSBs).
  - Latency stays 2 cycles and strobes are unchanged.
- Undefined: bypass port and mux are absent, and the LUT path is always used.

Test Plan:
- Reset, then write identity to shadow ch0..2 (entry n = n>>2 for DI=10, DO=8), pulse lut_swap, drive vs_i 0->1 -> lut_swap_done pulses once, lut_bank=1; pixel di ch0=0x3FF gives do ch0=0xFF exactly 2 cycles later, with de_o aligned.
- Write ch1 entry 5 = 0x0123 -> out-of-range saturation: ch1 input 5 outputs 0xFF. Entry 5 = 0x0042 -> outputs 0x42.
- Host port: ram_rd on a written address -> ram_rvalid one cycle later with the written value. Simultaneous wr+rd of 0xABCD -> rdata 0xABCD. Access with channel=3 (CH_COUNT=3) -> write ignored, read returns 0.
- Swap timing: lut_swap mid-frame -> lut_bank unchanged until next vs_i rising edge. Pixels before the edge use the old bank, pixels after use the new one. Three lut_swap pulses before the edge -> a single toggle.
- Assert rst=0 mid-line with de_i=1 -> the following cycle do_o=0, de_o=0, lut_bank=0. Release -> valid output 2 cycles after the first de_i.
- VIDEO_LUT_MC_BYPASS_EN build: bypass=1, di ch2=0x2A5 -> do ch2=0xA9 after 2 cycles. Toggle bypass per pixel -> no latency change.
